// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper for an N-input, 1-output function block.
// Steps every input code, settles, samples and compares against a table.
module truth_table_sweeper #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2**WIDTH-1:0]   expected,
  output logic [WIDTH-1:0]      dut_a,
  input  logic                  dut_y,
  output logic                  busy,
  output logic                  done,
  output logic [2**WIDTH-1:0]   table_out,
  output logic                  mismatch,
  output logic [WIDTH:0]        mismatch_count,
  output logic [WIDTH-1:0]      first_fail
);

  localparam int N = 2 ** WIDTH;
  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);
  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);
  localparam logic [WIDTH:0] ONE = (WIDTH + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DONE
  } state_t;

  state_t     state;
  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      dut_a          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      table_out      <= '0;
      mismatch       <= 1'b0;
      mismatch_count <= '0;
      first_fail     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          busy  <= 1'b0;
          dut_a <= '0;
          if (start) begin
            table_out      <= '0;
            mismatch       <= 1'b0;
            mismatch_count <= '0;
            first_fail     <= '0;
            cnt            <= SETTLE_CNT;
            busy           <= 1'b1;
            state          <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) state <= SAMPLE;
        end
        SAMPLE: begin
          table_out[dut_a] <= dut_y;
          if (dut_y != expected[dut_a]) begin
            mismatch_count <= mismatch_count + ONE;
            mismatch       <= 1'b1;
            // mismatch is still clear only before the first failing code
            if (!mismatch) first_fail <= dut_a;
          end
          if (dut_a == LAST) begin
            dut_a <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            dut_a <= dut_a + 1'b1;
            cnt   <= SETTLE_CNT;
            state <= WAIT;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
Self-contained sequencer that exhaustively drives a combinational N-input, 1-output function block through all 2**WIDTH input codes in ascending order. It waits a programmable settle time per code, captures the output into a truth-table register and compares each captured bit against an expected table. It sits between a start/done control interface and the combinational block under test, so a sweep can run in silicon or simulation without a hand-written stimulus list.

Parameters:
WIDTH, 4, input code width driven to the function block; table size is 2**WIDTH bits.
SETTLE, 2, cycles each code is held before sampling; legal range 1..15.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  sweep request; sampled only in IDLE.
expected  input  2**WIDTH  expected truth table; bit i = expected output for code i. Sampled bit-by-bit during SAMPLE.
dut_a  output  WIDTH  input code driven to the function block (bit WIDTH-1 = A ... bit 0 = D).
dut_y  input  1  function block output.
busy  output  1  high while a sweep is in progress (WAIT/SAMPLE).
done  output  1  single-cycle pulse when a sweep completes.
table_out  output  2**WIDTH  captured truth table; bit i = dut_y sampled for code i.
mismatch  output  1  high if any captured bit differed from expected.
mismatch_count  output  WIDTH+1  number of differing codes (0..2**WIDTH; no saturation needed).
first_fail  output  WIDTH  lowest code that mismatched; valid only when mismatch=1.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; dut_a=0, busy=0, done=0, table_out=0, mismatch=0, mismatch_count=0, first_fail=0. Reset wins over every other event, including mid-sweep; no partial results are retained.
- FSM states: IDLE, WAIT, SAMPLE, DONE.
- IDLE: busy=0, dut_a=0. Results from the previous sweep are held. If start=1: clear table_out, mismatch, mismatch_count and first_fail; load settle counter=SETTLE; go to WAIT. If start=0: remain in IDLE.
- WAIT: busy=1; dut_a held stable. Decrement the settle counter each cycle. After exactly SETTLE cycles in WAIT, go to SAMPLE.
- SAMPLE (one cycle): busy=1, dut_a unchanged. On the exiting edge:
  - table_out[dut_a] <= dut_y.
  - If dut_y != expected[dut_a]: increment mismatch_count and set mismatch=1. If this is the first mismatch of the sweep, first_fail <= dut_a.
  - If dut_a == 2**WIDTH-1: go to DONE and set dut_a <= 0.
  - Otherwise: dut_a <= dut_a+1, reload counter=SETTLE, go to WAIT.
- DONE (one cycle): done=1, busy=0. Next state is IDLE unconditionally. start is ignored in this cycle.
- Timing: each code occupies SETTLE+1 cycles. If start is accepted at edge k, busy is high for cycles k+1 .. k+(2**WIDTH)*(SETTLE+1). done is high in the following cycle. For defaults: busy for 48 cycles, done at cycle k+49.
- start is ignored while busy or in DONE; no queuing.
- Holding start high continuously causes back-to-back sweeps, one IDLE cycle apart.
- All outputs are registered. No combinational path exists from dut_y to any output.
- expected may change between sweeps; a mid-sweep change affects only codes sampled afterwards.

Test Plan:
- Bench models the function block as dut_y = F[dut_a] with F=16'h6996 (4-input parity); expected=16'h6996; pulse start one cycle -> dut_a steps 0..15 holding each for 3 cycles; done pulses once at start+49; table_out=16'h6996, mismatch=0, mismatch_count=0.
- Same F, expected=16'h6986 -> table_out=16'h6996, mismatch=1, mismatch_count=1, first_fail=4.
- Same F, expected=~16'h6996 -> mismatch_count=16 (5'b10000), first_fail=0; then a new sweep with correct expected -> all result fields clear to 0 on start and finish clean.
- Assert rst for one cycle while dut_a=7 in WAIT -> next cycle: IDLE, dut_a=0, busy=0, table_out=0, mismatch_count=0; no done pulse; a subsequent start runs a full, correct sweep.
- Pulse start again at cycles start+5 and start+48 (last SAMPLE) -> ignored; exactly one done pulse, timing unchanged.
- SETTLE=1 build, F=16'hFFFF, expected=16'hFFFF -> 32 busy cycles, done at start+33, table_out=16'hFFFF, mismatch=0.
